spike_clip_ctrl: RTL and testbench

Capture sequencer for the 8-bit spike-clip filter in the oscilloscope datapath. It feeds ADC samples to the filter and tracks sample validity through the filter's fixed latency. It discards warm-up outputs, then writes a programmed number of filtered samples into the capture RAM and counts both kinds of spike replacement. A bypass mode routes raw ADC samples to the RAM instead.

---
 rtl/spike_clip_ctrl.sv | 142 ++++++++++++++
 tb/tb_spike_clip_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_clip_ctrl.sv
// Capture sequencer for the spike-clip filter: tracks sample validity through the filter
// latency, discards warm-up outputs and writes a programmed sample count to the capture RAM.
module spike_clip_ctrl #(
    parameter int DW   = 8,
    parameter int AW   = 10,
    parameter int LAT  = 4,
    parameter int FILL = 4,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   cfg_len,
    input  logic          cfg_bypass,
    input  logic [DW-1:0] adc_din,
    input  logic          adc_valid,
    output logic [DW-1:0] filt_din,
    input  logic [DW-1:0] filt_dout,
    input  logic          filt_rep_sum,
    input  logic          filt_rep_x3,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] spike_cnt_sum,
    output logic [CW-1:0] spike_cnt_x3
);
    localparam int FCW = (FILL > 1) ? $clog2(FILL) : 1;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CAPTURE, S_DONE} state_t;

    state_t         state, state_n;
    logic [LAT-1:0] vpipe;
    logic           rep_sum_q, rep_x3_q;
    logic [AW:0]    len_q, wcnt, wcnt_inc, len_clamped;
    logic           byp_q;
    logic [FCW-1:0] fill_cnt;
    logic           out_v, qual, do_wr, accept;
    logic [DW-1:0]  src;

    assign filt_din = adc_din;
    assign out_v    = vpipe[LAT-1];

    always_comb begin
        accept      = (state == S_IDLE) && start && !abort;
        len_clamped = (cfg_len > DEPTH) ? DEPTH : cfg_len;
        qual        = byp_q ? adc_valid : out_v;
        src         = byp_q ? adc_din : filt_dout;
        do_wr       = (state == S_CAPTURE) && qual;
        wcnt_inc    = wcnt + 1'b1;
        state_n     = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cfg_len == '0)
                        state_n = S_DONE;
                    else if (cfg_bypass || FILL == 0)
                        state_n = S_CAPTURE;
                    else
                        state_n = S_FILL;
                end
            end
            S_FILL: begin
                if (abort)
                    state_n = S_IDLE;
                else if (out_v && fill_cnt == FCW'(FILL - 1))
                    state_n = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort)
                    state_n = S_IDLE;
                else if (do_wr && wcnt_inc == len_q)
                    state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            vpipe         <= '0;
            rep_sum_q     <= 1'b0;
            rep_x3_q      <= 1'b0;
            len_q         <= '0;
            byp_q         <= 1'b0;
            wcnt          <= '0;
            fill_cnt      <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            spike_cnt_sum <= '0;
            spike_cnt_x3  <= '0;
        end else begin
            state    <= state_n;
            vpipe[0] <= adc_valid;
            for (int unsigned i = 1; i < LAT; i++)
                vpipe[i] <= vpipe[i-1];
            // Flags lead filt_dout by one clock; one register aligns them with out_v.
            rep_sum_q <= filt_rep_sum;
            rep_x3_q  <= filt_rep_x3;
            busy      <= (state_n == S_FILL) || (state_n == S_CAPTURE);
            done      <= (state == S_DONE);
            wr_en     <= do_wr;
            if (do_wr)
                wr_data <= src;
            if (accept) begin
                len_q         <= len_clamped;
                byp_q         <= cfg_bypass;
                wcnt          <= '0;
                fill_cnt      <= '0;
                wr_addr       <= '0;
                spike_cnt_sum <= '0;
                spike_cnt_x3  <= '0;
            end else begin
                // wr_addr is the write index: it advances once each issued write has been presented.
                if (wr_en)
                    wr_addr <= wr_addr + 1'b1;
                if (state == S_FILL && out_v)
                    fill_cnt <= fill_cnt + 1'b1;
                if (do_wr) begin
                    wcnt <= wcnt_inc;
                    if (!byp_q) begin
                        if (rep_x3_q) begin
                            if (spike_cnt_x3 != '1)
                                spike_cnt_x3 <= spike_cnt_x3 + 1'b1;
                        end else if (rep_sum_q) begin
                            if (spike_cnt_sum != '1)
                                spike_cnt_sum <= spike_cnt_sum + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_clip_ctrl.sv
// Self-checking bench for spike_clip_ctrl: a behavioural spike-clip filter drives the DUT,
// and expected RAM writes are derived from the stimulus history with a transaction model.
module tb_spike_clip_ctrl;
    localparam int DW = 8, AW = 10, LAT = 4, FILL = 4, CW = 16;
    localparam int DEPTH = 1 << AW;
    localparam int HM = 4095;
    localparam int TH = 10;

    typedef struct {int t; int a; int d;} wr_t;
    typedef struct {int t; int a; int d; bit fs; bit fx;} ex_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, cfg_bypass, adc_valid;
    logic [AW:0]   cfg_len;
    logic [DW-1:0] adc_din, filt_din, filt_dout, wr_data;
    logic          filt_rep_sum, filt_rep_x3, wr_en, busy, done;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] spike_cnt_sum, spike_cnt_x3;

    int  checks = 0, errors = 0;
    int  cyc = 0;
    int  hist [0:HM];
    bit  hv   [0:HM];
    wr_t wq[$];
    int  dq[$];
    int  busy_cnt = 0;
    wr_t mw;
    ex_t eq[$];
    int  exp_sum, exp_x3, exp_done, exp_busy, leff;
    int  wb, db, bb;
    logic snap_busy, snap_wr_en, snap_done;
    int  snap_addr, snap_data, snap_sum, snap_x3;

    spike_clip_ctrl #(.DW(DW), .AW(AW), .LAT(LAT), .FILL(FILL), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .cfg_bypass(cfg_bypass), .adc_din(adc_din), .adc_valid(adc_valid),
        .filt_din(filt_din), .filt_dout(filt_dout), .filt_rep_sum(filt_rep_sum),
        .filt_rep_x3(filt_rep_x3), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .spike_cnt_sum(spike_cnt_sum), .spike_cnt_x3(spike_cnt_x3)
    );

    always #5 clk = ~clk;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // 3-tap spike clip on the sample stream centred at cycle ctr.
    function automatic void filt(input int ctr, output int d, output bit fs, output bit fx);
        int p, c, n;
        p = hist[(ctr - 1) & HM]; c = hist[ctr & HM]; n = hist[(ctr + 1) & HM];
        d = c; fs = 1'b0; fx = 1'b0;
        if (absd(c, p) > TH && absd(c, n) > TH) begin
            if (absd(p, n) <= TH) begin d = (p + n) / 2; fs = 1'b1; end
            else begin d = p; fx = 1'b1; end
        end
    endfunction

    // Filter stand-in: output for the sample driven LAT cycles ago, flags one cycle earlier.
    always @(posedge clk) begin
        int d; bit fs, fx;
        hist[cyc & HM] = int'(adc_din);
        hv[cyc & HM]   = adc_valid;
        cyc = cyc + 1;
        #1;
        filt(cyc - LAT, d, fs, fx);
        filt_dout = DW'(d);
        filt(cyc + 1 - LAT, d, fs, fx);
        filt_rep_sum = fs;
        filt_rep_x3  = fx;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            mw.t = cyc; mw.a = int'(wr_addr); mw.d = int'(wr_data);
            wq.push_back(mw);
        end
        if (done) dq.push_back(cyc);
        if (busy) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_run(input int len, input bit byp, input int kind, input int ncyc,
                             input int abort_at, input int rst_at, input int bstart_at,
                             output int s);
        int snap_at;
        snap_at = (abort_at > 0) ? abort_at + 1 : ((rst_at > 0) ? rst_at + 1 : -1);
        @(posedge clk); #1;
        wb = wq.size(); db = dq.size(); bb = busy_cnt;
        s = cyc;
        start = 1'b1; abort = (abort_at == 0); cfg_len = len[AW:0]; cfg_bypass = byp;
        adc_valid = 1'b0; adc_din = DW'($urandom);
        for (int i = 1; i <= ncyc + LAT + 6; i++) begin
            @(posedge clk); #1;
            start = (i == bstart_at); abort = (i == abort_at); rst = (i == rst_at);
            if (i == bstart_at) begin cfg_len = 2; cfg_bypass = !byp; end
            if (i <= ncyc) begin
                case (kind)
                    0: begin adc_din = DW'(i - 1); adc_valid = 1'b1; end
                    1: begin adc_din = (i == 10) ? 8'd120 : 8'd100; adc_valid = 1'b1; end
                    2: begin adc_din = DW'($urandom); adc_valid = i[0]; end
                    3: begin
                        adc_din = DW'(50 + $urandom_range(0, 6));
                        if ($urandom_range(0, 7) == 0) adc_din = DW'($urandom_range(0, 255));
                        adc_valid = (i % 4 != 3) || ($urandom_range(0, 1) == 1);
                    end
                    default: begin adc_din = DW'($urandom); adc_valid = 1'b1; end
                endcase
            end else begin
                adc_valid = 1'b0;
            end
            if (i == snap_at) begin
                @(negedge clk);
                snap_busy = busy; snap_wr_en = wr_en; snap_done = done;
                snap_addr = int'(wr_addr); snap_data = int'(wr_data);
                snap_sum = int'(spike_cnt_sum); snap_x3 = int'(spike_cnt_x3);
            end
        end
    endtask

    // Transaction model: n-th accepted sample after start -> n-th write.
    task automatic build_expect(input int s, input int len, input bit byp, input int ncyc);
        int k, n, d; bit fs, fx; ex_t e;
        eq.delete(); exp_sum = 0; exp_x3 = 0; k = 0; n = 0;
        leff = (len > DEPTH) ? DEPTH : len;
        for (int c = s + 1; c <= s + ncyc; c++) begin
            if (hv[c & HM]) begin
                if (byp) begin
                    if (n < leff) begin
                        e.t = c + 1; e.a = n % DEPTH; e.d = hist[c & HM]; e.fs = 0; e.fx = 0;
                        eq.push_back(e); n++;
                    end
                end else begin
                    if (k >= FILL && n < leff) begin
                        filt(c, d, fs, fx);
                        e.t = c + LAT + 1; e.a = n % DEPTH; e.d = d; e.fs = fs; e.fx = fx;
                        eq.push_back(e); n++;
                        if (fx) exp_x3++; else if (fs) exp_sum++;
                    end
                    k++;
                end
            end
        end
        exp_done = (leff == 0) ? s + 2 : ((eq.size() == leff) ? eq[eq.size()-1].t + 1 : -1);
        exp_busy = (leff == 0) ? 0 : eq[eq.size()-1].t - s - 1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %0b exp 0", wr_en); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL rst_wr_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL rst_wr_data got %0d exp 0", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
        checks++; if (spike_cnt_sum !== '0) begin errors++; $display("FAIL rst_cnt_sum got %0d exp 0", spike_cnt_sum); end
        checks++; if (spike_cnt_x3 !== '0) begin errors++; $display("FAIL rst_cnt_x3 got %0d exp 0", spike_cnt_x3); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (LAT + 2) @(posedge clk);
    endtask

    task automatic test_rst_mid();
        int s, late;
        drive_run(20, 1'b0, 3, 40, -1, 12, -1, s);
        checks++;
        if ({snap_busy, snap_wr_en, snap_done} !== 3'b000 || snap_addr != 0 || snap_data != 0 ||
            snap_sum != 0 || snap_x3 != 0) begin
            errors++;
            $display("FAIL rst_mid got busy=%0b wr_en=%0b done=%0b addr=%0d data=%0d sum=%0d x3=%0d exp all 0",
                     snap_busy, snap_wr_en, snap_done, snap_addr, snap_data, snap_sum, snap_x3);
        end
        late = 0;
        for (int k = wb; k < wq.size(); k++) if (wq[k].t > s + 12) late++;
        checks++; if (late != 0) begin errors++; $display("FAIL rst_mid_writes got %0d exp 0", late); end
        checks++; if (dq.size() != db) begin errors++; $display("FAIL rst_mid_done got %0d exp 0", dq.size() - db); end
    endtask

    task automatic test_scenarios();
        int lens[8]  = '{1024, 8, 16, 3, 37, 25, 1, 2047};
        bit byps[8]  = '{0, 0, 0, 1, 0, 1, 0, 1};
        int kinds[8] = '{4, 0, 1, 2, 3, 3, 3, 4};
        int s, ncyc, obs, l;
        for (int r = 0; r < 8; r++) begin
            l = (lens[r] > DEPTH) ? DEPTH : lens[r];
            ncyc = 2 * (l + FILL) + 8;
            drive_run(lens[r], byps[r], kinds[r], ncyc, -1, -1, -1, s);
            build_expect(s, lens[r], byps[r], ncyc);
            obs = wq.size() - wb;
            checks++;
            if (obs != eq.size()) begin errors++; $display("FAIL run%0d_wr_count got %0d exp %0d", r, obs, eq.size()); end
            for (int k = 0; k < obs && k < eq.size(); k++) begin
                checks++;
                if (wq[wb+k].t != eq[k].t || wq[wb+k].a != eq[k].a || wq[wb+k].d != eq[k].d) begin
                    errors++;
                    $display("FAIL run%0d_wr%0d got t=%0d a=%0d d=%0d exp t=%0d a=%0d d=%0d", r, k,
                             wq[wb+k].t - s, wq[wb+k].a, wq[wb+k].d, eq[k].t - s, eq[k].a, eq[k].d);
                end
            end
            checks++;
            if (spike_cnt_sum !== CW'(exp_sum) || spike_cnt_x3 !== CW'(exp_x3)) begin
                errors++;
                $display("FAIL run%0d_counters got sum=%0d x3=%0d exp sum=%0d x3=%0d", r,
                         spike_cnt_sum, spike_cnt_x3, exp_sum, exp_x3);
            end
            checks++;
            if (dq.size() - db != 1 || dq[dq.size()-1] != exp_done) begin
                errors++;
                $display("FAIL run%0d_done got n=%0d t=%0d exp n=1 t=%0d", r, dq.size() - db,
                         (dq.size() > db) ? dq[dq.size()-1] - s : -1, exp_done - s);
            end
            checks++;
            if (busy_cnt - bb != exp_busy) begin errors++; $display("FAIL run%0d_busy_cycles got %0d exp %0d", r, busy_cnt - bb, exp_busy); end
            checks++;
            if (int'(wr_addr) != l % DEPTH) begin errors++; $display("FAIL run%0d_final_addr got %0d exp %0d", r, wr_addr, l % DEPTH); end
            if (r == 1) begin
                for (int k = 0; k < obs && k < 8; k++) begin
                    checks++;
                    if (wq[wb+k].d != k + 4) begin errors++; $display("FAIL ramp_data%0d got %0d exp %0d", k, wq[wb+k].d, k + 4); end
                end
                checks++;
                if (spike_cnt_sum !== '0 || spike_cnt_x3 !== '0) begin
                    errors++; $display("FAIL ramp_counters got sum=%0d x3=%0d exp 0 0", spike_cnt_sum, spike_cnt_x3);
                end
            end
            if (r == 2) begin
                checks++;
                if (spike_cnt_sum !== CW'(1) || spike_cnt_x3 !== '0) begin
                    errors++; $display("FAIL spike_counters got sum=%0d x3=%0d exp 1 0", spike_cnt_sum, spike_cnt_x3);
                end
                for (int k = 0; k < obs; k++) begin
                    checks++;
                    if (wq[wb+k].d != 100) begin errors++; $display("FAIL spike_data%0d got %0d exp 100", k, wq[wb+k].d); end
                end
            end
        end
    endtask

    task automatic test_len0();
        int s;
        drive_run(0, 1'b0, 4, 10, -1, -1, -1, s);
        checks++; if (wq.size() != wb) begin errors++; $display("FAIL len0_writes got %0d exp 0", wq.size() - wb); end
        checks++; if (busy_cnt != bb) begin errors++; $display("FAIL len0_busy got %0d exp 0", busy_cnt - bb); end
        checks++;
        if (dq.size() - db != 1 || dq[dq.size()-1] != s + 2) begin
            errors++;
            $display("FAIL len0_done got n=%0d t=%0d exp n=1 t=2", dq.size() - db,
                     (dq.size() > db) ? dq[dq.size()-1] - s : -1);
        end
    endtask

    task automatic test_start_abort_idle();
        int s;
        drive_run(5, 1'b1, 4, 20, 0, -1, -1, s);
        checks++; if (wq.size() != wb) begin errors++; $display("FAIL start_abort_writes got %0d exp 0", wq.size() - wb); end
        checks++; if (busy_cnt != bb) begin errors++; $display("FAIL start_abort_busy got %0d exp 0", busy_cnt - bb); end
        checks++; if (dq.size() != db) begin errors++; $display("FAIL start_abort_done got %0d exp 0", dq.size() - db); end
    endtask

    task automatic test_abort();
        int s, nb, obs, es, ex;
        drive_run(20, 1'b0, 4, 40, 14, -1, 3, s);
        build_expect(s, 20, 1'b0, 40);
        nb = 0;
        for (int k = 0; k < eq.size(); k++) if (eq[k].t <= s + 14) nb++;
        obs = wq.size() - wb;
        checks++;
        if (obs != nb && obs != nb + 1) begin errors++; $display("FAIL abort_wr_count got %0d exp %0d or %0d", obs, nb, nb + 1); end
        es = 0; ex = 0;
        for (int k = 0; k < obs && k < eq.size(); k++) begin
            if (eq[k].fx) ex++; else if (eq[k].fs) es++;
            checks++;
            if (wq[wb+k].t != eq[k].t || wq[wb+k].a != eq[k].a || wq[wb+k].d != eq[k].d) begin
                errors++;
                $display("FAIL abort_wr%0d got t=%0d a=%0d d=%0d exp t=%0d a=%0d d=%0d", k,
                         wq[wb+k].t - s, wq[wb+k].a, wq[wb+k].d, eq[k].t - s, eq[k].a, eq[k].d);
            end
        end
        checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", snap_busy); end
        checks++; if (dq.size() != db) begin errors++; $display("FAIL abort_done got %0d exp 0", dq.size() - db); end
        checks++;
        if (spike_cnt_sum !== CW'(es) || spike_cnt_x3 !== CW'(ex)) begin
            errors++; $display("FAIL abort_counters got sum=%0d x3=%0d exp %0d %0d", spike_cnt_sum, spike_cnt_x3, es, ex);
        end
        checks++; if (int'(wr_addr) != obs) begin errors++; $display("FAIL abort_addr got %0d exp %0d", wr_addr, obs); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_len = '0; cfg_bypass = 1'b0;
        adc_din = '0; adc_valid = 1'b0;
        test_reset();
        test_rst_mid();
        test_scenarios();
        test_len0();
        test_start_abort_idle();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
